// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - FSM states, SPI frame layout and frame builder for dac_spi_tx
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } dac_spi_state_t;

  localparam int FRAME_BITS   = 16;
  localparam int HDR_CH_BIT   = 15;
  localparam int HDR_BUF_BIT  = 14;
  localparam int HDR_GA_BIT   = 13;
  localparam int HDR_SHDN_BIT = 12;

  // Channel A, unbuffered, active; code is already left-aligned to 12 bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       gain_x1,
                                                        input logic [11:0] code);
    logic [FRAME_BITS-1:0] w;
    w               = '0;
    w[HDR_CH_BIT]   = 1'b0;
    w[HDR_BUF_BIT]  = 1'b0;
    w[HDR_GA_BIT]   = gain_x1;
    w[HDR_SHDN_BIT] = 1'b1;
    w[11:0]         = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_spi_clkdiv.sv
// rtl/dac_spi_clkdiv.sv - SCLK half-period divider producing rise/fall strobes
// Strobes fire on the last clk of each low (rise_en) or high (fall_en) half-period.
module dac_spi_clkdiv
  import dac_spi_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap    = run && (cnt == CW'(SCLK_DIV - 1));
  assign rise_en = wrap && !phase;
  assign fall_en = wrap && phase;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - MCP4921-style SPI DAC transmitter with per-frame sample tick
// Optional LDAC strobe generation is enabled by defining DAC_LDAC_EN.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int AMP_WIDTH      = 12,
  parameter int SCLK_DIV       = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [AMP_WIDTH-1:0] sample_in,
  input  logic                 gain_x1,
  output logic                 sample_tick,
  output logic                 busy,
  output logic                 dac_cs_n,
  output logic                 dac_sclk,
  output logic                 dac_mosi,
  output logic                 dac_ldac_n
);

  localparam int GW  = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam int PAD = 12 - AMP_WIDTH;

  dac_spi_state_t state, next_state;

  logic [3:0]            bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [FRAME_BITS-2:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [11:0]           code12;
  logic                  rise_en, fall_en;
  logic                  last_bit, gap_done, in_shift;
  logic                  cs_n_q, sclk_q, mosi_q, tick_q, busy_q;

  assign code12     = 12'(sample_in) << PAD;
  assign frame_word = build_frame(gain_x1, code12);
  assign last_bit   = (bit_cnt == 4'(FRAME_BITS - 1));
  assign gap_done   = (gap_cnt == GW'(CS_HIGH_CYCLES - 1));
  assign in_shift   = (state == SHIFT);

  dac_spi_clkdiv #(
    .SCLK_DIV(SCLK_DIV)
  ) u_clkdiv (
    .clk    (clk),
    .rst    (rst),
    .run    (in_shift),
    .rise_en(rise_en),
    .fall_en(fall_en)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (fall_en && last_bit) next_state = GAP;
      GAP:     if (gap_done) next_state = enable ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so each one lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tick_q <= (next_state == LOAD);
      busy_q <= (next_state != IDLE);
      cs_n_q <= !((next_state == LOAD) || (next_state == SHIFT));
      case (state)
        LOAD: begin
          shreg   <= frame_word[FRAME_BITS-2:0];
          mosi_q  <= frame_word[FRAME_BITS-1];
          sclk_q  <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (rise_en) sclk_q <= 1'b1;
          if (fall_en) begin
            sclk_q <= 1'b0;
            if (last_bit) begin
              bit_cnt <= '0;
              gap_cnt <= '0;
              mosi_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi_q  <= shreg[FRAME_BITS-2];
              shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        GAP: begin
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
        end
        default: begin
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          bit_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  assign sample_tick = tick_q;
  assign busy        = busy_q;
  assign dac_cs_n    = cs_n_q;
  assign dac_sclk    = sclk_q;
  assign dac_mosi    = mosi_q;

`ifdef DAC_LDAC_EN
  // Low on the second GAP cycle: registered off the first GAP cycle.
  logic ldac_n_q;
  always_ff @(posedge clk) begin
    if (rst) ldac_n_q <= 1'b1;
    else     ldac_n_q <= !((state == GAP) && (gap_cnt == '0));
  end
  assign dac_ldac_n = ldac_n_q;
`else
  assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - scoreboard bench for dac_spi_tx (default parameters)
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] sample_in = '0;
  logic        gain_x1 = 1'b0;
  logic        sample_tick, busy, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n;

  dac_spi_tx dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sample_in  (sample_in),
    .gain_x1    (gain_x1),
    .sample_tick(sample_tick),
    .busy       (busy),
    .dac_cs_n   (dac_cs_n),
    .dac_sclk   (dac_sclk),
    .dac_mosi   (dac_mosi),
    .dac_ldac_n (dac_ldac_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  bit          gap_check_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: decodes frames from the SPI pins and checks them against the queue.
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] sh = '0;
  logic [15:0] exp_w;
  int          rises = 0;
  int          hi_run = 0;
  int          last_tick = -1;
  bit          aborted = 0;

  always @(negedge clk) begin
    if (rst && !dac_cs_n) aborted = 1;
    if (!dac_cs_n && !prev_sclk && dac_sclk) begin
      sh = {sh[14:0], dac_mosi};
      rises++;
    end
    if (prev_cs && !dac_cs_n) begin
      if (gap_check_en) chk("cs_high_gap", hi_run, 4);
      sh    = '0;
      rises = 0;
    end
    if (!prev_cs && dac_cs_n) begin
      if (aborted) aborted = 0;
      else if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
      else begin
        exp_w = exp_q.pop_front();
        chk("frame_word", sh, exp_w);
        chk("sclk_rises", rises, 16);
      end
    end
    if (sample_tick) begin
      if (gap_check_en && last_tick >= 0) chk("tick_period", cyc - last_tick, 69);
      last_tick = cyc;
    end
    hi_run = dac_cs_n ? hi_run + 1 : 0;
`ifdef DAC_LDAC_EN
    if (!rst && !dac_ldac_n) chk("ldac_gap_cycle", hi_run, 2);
`endif
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
  end

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic issue(input logic [11:0] s, input logic g, input logic [15:0] e, input bit push);
    bit ok;
    sample_in = s;
    gain_x1   = g;
    wait_tick(ok);
    chk("tick_seen", ok, 1);
    if (ok && push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  logic [11:0] vs[5] = '{12'h000, 12'hFFF, 12'h123, 12'h456, 12'h800};
  logic        vg[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] ve[5] = '{16'h1000, 16'h1FFF, 16'h3123, 16'h3456, 16'h3800};

  initial begin
    int ticks;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_mosi", dac_mosi, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_busy", busy, 0);
`ifdef DAC_LDAC_EN
    chk("rst_ldac_n", dac_ldac_n, 1);
`else
    chk("rst_ldac_n", dac_ldac_n, 0);
`endif

    // Start latency: enable sampled at the next edge, CS low one cycle later.
    sample_in = 12'hABC;
    gain_x1   = 1'b1;
    enable    = 1'b1;
    @(negedge clk);
    chk("start_cs_low", dac_cs_n, 0);
    chk("start_tick", sample_tick, 1);
    exp_q.push_back(16'h3ABC);
    @(posedge clk);
    #1 gap_check_en = 1;

    // Continuous frames; each new value is driven mid-SHIFT of the previous frame.
    for (int i = 0; i < 5; i++) begin
      repeat (20) @(posedge clk);
      #1;
      issue(vs[i], vg[i], ve[i], 1);
    end

    // Drop enable around bit 8 of the last frame.
    repeat (32) @(posedge clk);
    #1;
    chk("busy_mid_frame", busy, 1);
    enable       = 1'b0;
    gap_check_en = 0;
    wait_idle("idle_after_drop");
    chk("drop_cs_n", dac_cs_n, 1);
    chk("drop_sclk", dac_sclk, 0);
    ticks = 0;
    repeat (150) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
    chk("no_tick_after_drop", ticks, 0);
    chk("queue_drained", exp_q.size(), 0);

    // Reset in the middle of bit 5.
    enable = 1'b1;
    issue(12'h5A5, 1'b1, 16'h35A5, 0);
    repeat (20) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cs_n", dac_cs_n, 1);
    chk("midrst_sclk", dac_sclk, 0);
    chk("midrst_mosi", dac_mosi, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Recovery frame after reset.
    enable = 1'b1;
    issue(12'h7E1, 1'b0, 16'h17E1, 1);
    enable = 1'b0;
    wait_idle("idle_after_recovery");
    repeat (4) @(negedge clk);
    chk("queue_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
